// File: rtl/mmio_responder_pkg.sv
// mmio_responder_pkg
//   Shared constants for the MMIO responder: register addresses, status
//   register bit positions, rx buffer depths and the address decoder.
//   Imported by mmio_responder and mmio_rx_fifo.
package mmio_responder_pkg;

    // Register map (full 32-bit byte addresses; bit 31 marks MMIO space).
    localparam logic [31:0] ADDR_STATUS = 32'h8000_0000;
    localparam logic [31:0] ADDR_RX     = 32'h8000_0004;
    localparam logic [31:0] ADDR_TX     = 32'h8000_0008;
    localparam logic [31:0] ADDR_CYC    = 32'h8000_0010;
    localparam logic [31:0] ADDR_INST   = 32'h8000_0014;
    localparam logic [31:0] ADDR_CLR    = 32'h8000_0018;

    // Status register bit positions.
    localparam int STAT_TX_FREE  = 0;
    localparam int STAT_RX_AVAIL = 1;

    // Rx storage depth with and without the FIFO option.
    localparam int RX_DEPTH_FIFO = 4;
    localparam int RX_DEPTH_REG  = 1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_STATUS,
        REG_RX,
        REG_TX,
        REG_CYC,
        REG_INST,
        REG_CLR
    } mmio_reg_e;

    // Anything outside MMIO space, or an unmapped MMIO address, decodes to
    // REG_NONE, which reads as zero and has no write side effect.
    function automatic mmio_reg_e decode_addr(input logic [31:0] a);
        if (!a[31]) begin
            return REG_NONE;
        end
        case (a)
            ADDR_STATUS: return REG_STATUS;
            ADDR_RX:     return REG_RX;
            ADDR_TX:     return REG_TX;
            ADDR_CYC:    return REG_CYC;
            ADDR_INST:   return REG_INST;
            ADDR_CLR:    return REG_CLR;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mmio_responder_rx_fifo.sv
// mmio_rx_fifo
//   Byte storage for the UART receive path. DEPTH=1 is a single holding
//   register (full whenever a byte is held); DEPTH=4 is a circular FIFO.
//   DEPTH must be 1 or a power of two so pointers wrap naturally.
// Ports:
//   clk        - clock
//   reset      - asynchronous active-high reset, empties the storage
//   push       - capture push_data this cycle (ignored when full)
//   push_data  - byte to capture
//   pop        - drop the oldest byte this cycle (ignored when empty)
//   head       - oldest byte (undefined content when empty)
//   avail      - at least one byte held
//   full       - no room for another byte
module mmio_rx_fifo
    import mmio_responder_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH_REG
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       avail,
    output logic       full
);

    logic push_ok;
    logic pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && avail;

    generate
        if (DEPTH == 1) begin : g_reg
            logic [7:0] data_q;
            logic       valid_q;

            // Pop and push cannot coincide here: push needs the register
            // empty and pop needs it full.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q  <= 8'h00;
                    valid_q <= 1'b0;
                end else begin
                    if (pop_ok) begin
                        valid_q <= 1'b0;
                    end
                    if (push_ok) begin
                        valid_q <= 1'b1;
                        data_q  <= push_data;
                    end
                end
            end

            assign head  = data_q;
            assign avail = valid_q;
            assign full  = valid_q;
        end else begin : g_fifo
            localparam int PTR_W = $clog2(DEPTH);
            localparam int CNT_W = $clog2(DEPTH + 1);
            localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

            logic [7:0]       mem [DEPTH];
            logic [PTR_W-1:0] rd_ptr;
            logic [PTR_W-1:0] wr_ptr;
            logic [CNT_W-1:0] count;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (pop_ok) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    if (push_ok) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
                end
            end

            // Storage needs no reset: emptiness is tracked by count alone.
            always_ff @(posedge clk) begin
                if (push_ok) begin
                    mem[wr_ptr] <= push_data;
                end
            end

            assign head  = mem[rd_ptr];
            assign avail = (count != '0);
            assign full  = (count == FULL_CNT);
        end
    endgenerate

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder
//   Memory-mapped I/O block on the data side of the pipeline. Accesses with
//   addr[31]=1 hit this block instead of the DCache. Provides a UART byte
//   source/sink, a free-running cycle counter and a retired-instruction
//   counter. Loads return data one cycle after re, matching DCache timing.
//   Build option: define MMIO_RX_FIFO_EN for a 4-entry rx FIFO; otherwise
//   rx uses a single byte register.
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   addr, wdata, we, st_size - store/load address, store data, store strobe,
//                              store size (unused: all registers are word or
//                              byte wide and tx takes wdata[7:0])
//   re                       - load strobe
//   inst_valid               - one instruction retired this cycle
//   rdata, mmio_sel          - registered load data and writeback select
//   uart_tx_data/valid/ready - byte stream toward the UART transmitter
//   uart_rx_data/valid/ready - byte stream from the UART receiver
module mmio_responder
    import mmio_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [1:0]  st_size,
    input  logic        re,
    input  logic        inst_valid,
    output logic [31:0] rdata,
    output logic        mmio_sel,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

`ifdef MMIO_RX_FIFO_EN
    localparam int RX_DEPTH = RX_DEPTH_FIFO;
`else
    localparam int RX_DEPTH = RX_DEPTH_REG;
`endif

    mmio_reg_e   reg_sel;
    logic        tx_wr;
    logic        cnt_clr;
    logic        rx_push;
    logic        rx_pop;
    logic [7:0]  rx_head;
    logic        rx_avail;
    logic        rx_full;
    logic [31:0] cyc_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] rd_val;
    logic        unused_bits;

    assign unused_bits = ^{st_size, wdata[31:8]};

    assign reg_sel = decode_addr(addr);
    assign tx_wr   = we && (reg_sel == REG_TX);
    assign cnt_clr = we && (reg_sel == REG_CLR);

    // ---------------- Load path ----------------
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_val[STAT_RX_AVAIL] = rx_avail;
                rd_val[STAT_TX_FREE]  = ~uart_tx_valid;
            end
            REG_RX:   rd_val[7:0] = rx_avail ? rx_head : 8'h00;
            REG_CYC:  rd_val = cyc_cnt;
            REG_INST: rd_val = inst_cnt;
            default:  rd_val = '0;
        endcase
    end

    // Load result holds until the next load; a non-MMIO load hands
    // writeback back to the DCache.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata    <= '0;
            mmio_sel <= 1'b0;
        end else if (re) begin
            rdata    <= rd_val;
            mmio_sel <= addr[31];
        end
    end

    // ---------------- Tx holding register ----------------
    // A write while the holder is occupied is dropped, including on the
    // handshake cycle itself (tx_free is still 0 then).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h00;
        end else if (uart_tx_valid) begin
            if (uart_tx_ready) begin
                uart_tx_valid <= 1'b0;
            end
        end else if (tx_wr) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= wdata[7:0];
        end
    end

    // ---------------- Rx storage ----------------
    assign uart_rx_ready = ~rx_full;
    assign rx_push       = uart_rx_valid && uart_rx_ready;
    assign rx_pop        = re && (reg_sel == REG_RX) && rx_avail;

    mmio_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (uart_rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .avail     (rx_avail),
        .full      (rx_full)
    );

    // ---------------- Counters ----------------
    // Clear wins over the same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else if (cnt_clr) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            cyc_cnt  <= cyc_cnt + 32'd1;
            inst_cnt <= inst_cnt + {31'b0, inst_valid};
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder
//   Self-checking bench for mmio_responder: directed scenarios followed by
//   randomized traffic, all checked cycle by cycle against a behavioural
//   model (rx as a bounded queue, counters as plain integers).
module tb_mmio_responder;

`ifdef MMIO_RX_FIFO_EN
    localparam int RXD = 4;
`else
    localparam int RXD = 1;
`endif

    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RX     = 32'h8000_0004;
    localparam logic [31:0] A_TX     = 32'h8000_0008;
    localparam logic [31:0] A_CYC    = 32'h8000_0010;
    localparam logic [31:0] A_INST   = 32'h8000_0014;
    localparam logic [31:0] A_CLR    = 32'h8000_0018;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic [1:0]  st_size = 2'd2;
    logic        re = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] rdata;
    logic        mmio_sel;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    mmio_responder dut (
        .clk           (clk),
        .reset         (reset),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .st_size       (st_size),
        .re            (re),
        .inst_valid    (inst_valid),
        .rdata         (rdata),
        .mmio_sel      (mmio_sel),
        .uart_tx_data  (tx_data),
        .uart_tx_valid (tx_valid),
        .uart_tx_ready (tx_ready),
        .uart_rx_data  (rx_data),
        .uart_rx_valid (rx_valid),
        .uart_rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_rdata;
    logic        m_sel;
    logic        m_txv;
    logic [7:0]  m_txd;
    logic [31:0] m_cyc;
    logic [31:0] m_inst;
    logic [7:0]  m_rxq[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rdata = '0;
        m_sel   = 1'b0;
        m_txv   = 1'b0;
        m_txd   = 8'h00;
        m_cyc   = '0;
        m_inst  = '0;
        m_rxq.delete();
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic avail;
        logic free;
        avail = (m_rxq.size() != 0);
        free  = !m_txv;
        if (a == A_STATUS) return {30'b0, avail, free};
        if (a == A_RX)     return avail ? {24'b0, m_rxq[0]} : 32'h0;
        if (a == A_CYC)    return m_cyc;
        if (a == A_INST)   return m_inst;
        return 32'h0;
    endfunction

    // Advance one clock: predict from current inputs, clock, compare.
    // Called with time at posedge+1 (inputs stable for the coming edge).
    task automatic tick();
        logic [31:0] n_rdata;
        logic        n_sel;
        logic        n_txv;
        logic [7:0]  n_txd;
        logic [31:0] n_cyc;
        logic [31:0] n_inst;
        logic        push;
        logic        pop;
        logic        clr;
        logic [7:0]  pdat;

        n_rdata = m_rdata;
        n_sel   = m_sel;
        if (re) begin
            n_sel   = addr[31];
            n_rdata = addr[31] ? m_read(addr) : 32'h0;
        end

        n_txv = m_txv;
        n_txd = m_txd;
        if (m_txv && tx_ready) n_txv = 1'b0;
        if (we && addr == A_TX && !m_txv) begin
            n_txv = 1'b1;
            n_txd = wdata[7:0];
        end

        pop  = re && addr == A_RX && m_rxq.size() != 0;
        push = rx_valid && (m_rxq.size() < RXD);
        pdat = rx_data;

        clr    = we && addr == A_CLR;
        n_cyc  = clr ? 32'h0 : m_cyc + 32'd1;
        n_inst = clr ? 32'h0 : m_inst + 32'(inst_valid);

        @(posedge clk);
        #1;

        m_rdata = n_rdata;
        m_sel   = n_sel;
        m_txv   = n_txv;
        m_txd   = n_txd;
        m_cyc   = n_cyc;
        m_inst  = n_inst;
        if (pop)  void'(m_rxq.pop_front());
        if (push) m_rxq.push_back(pdat);

        chk("rdata",    rdata,            m_rdata);
        chk("mmio_sel", 32'(mmio_sel),    32'(m_sel));
        chk("tx_valid", 32'(tx_valid),    32'(m_txv));
        chk("tx_data",  32'(tx_data),     32'(m_txd));
        chk("rx_ready", 32'(rx_ready),    32'(m_rxq.size() < RXD));
    endtask

    task automatic idle();
        we         = 1'b0;
        re         = 1'b0;
        inst_valid = 1'b0;
        rx_valid   = 1'b0;
        addr       = 32'h0;
    endtask

    // Asserts reset between edges and checks outputs cleared before the
    // next edge; releases reset before that edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
        chk({tag, "_tx_data"},  32'(tx_data),  32'h0);
        chk({tag, "_rdata"},    rdata,         32'h0);
        chk({tag, "_mmio_sel"}, 32'(mmio_sel), 32'h0);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'h1);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] addr_pool [8];
    logic [31:0] rnd;

    initial begin
        addr_pool = '{A_STATUS, A_RX, A_TX, A_CYC, A_INST, A_CLR,
                      32'h8000_000C, 32'h8000_0020};
        model_reset();
        #1;
        do_reset("rst0");

        // 10 idle cycles, then a cycle-counter read.
        idle();
        for (int i = 0; i < 10; i++) tick();
        re = 1'b1; addr = A_CYC;
        tick();
        chk("cyc10_rdata", rdata, 32'd10);
        chk("cyc10_sel", 32'(mmio_sel), 32'h1);
        idle();

        // Tx hold with ready low, dropped second write, then handshake.
        tx_ready = 1'b0;
        we = 1'b1; addr = A_TX; wdata = 32'h0000_0041;
        tick();
        chk("tx_load_valid", 32'(tx_valid), 32'h1);
        wdata = 32'h0000_0042;
        tick();
        chk("tx_drop_data", 32'(tx_data), 32'h41);
        idle();
        tick();
        chk("tx_hold_valid", 32'(tx_valid), 32'h1);
        tx_ready = 1'b1;
        tick();
        chk("tx_done_valid", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Rx: push five bytes, then drain with five reads and a status read.
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(8'h11 * (i + 1));
            tick();
        end
        idle();
        chk("rx_full_ready", 32'(rx_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            re = 1'b1; addr = A_RX;
            tick();
            chk("rx_pop_data", rdata, (i < RXD) ? 32'(8'h11 * (i + 1)) : 32'h0);
        end
        addr = A_STATUS;
        tick();
        chk("rx_empty_status", rdata, 32'h1);
        idle();

        // Instruction counter: five pulses, then clear colliding with inst_valid.
        inst_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        inst_valid = 1'b0;
        re = 1'b1; addr = A_INST;
        tick();
        chk("inst5", rdata, 32'd5);
        re = 1'b0; we = 1'b1; addr = A_CLR; inst_valid = 1'b1;
        tick();
        idle();
        re = 1'b1; addr = A_INST;
        tick();
        chk("inst_clr", rdata, 32'd0);
        idle();

        // Cycle counter wrap via preload, then a non-MMIO load.
        re = 1'b1; addr = A_CYC;
        force dut.cyc_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_cnt;
        m_cyc = 32'hFFFF_FFFF;
        tick();
        chk("cyc_max", rdata, 32'hFFFF_FFFF);
        tick();
        chk("cyc_wrap", rdata, 32'h0);
        addr = 32'h0000_1000;
        tick();
        chk("non_mmio_sel", 32'(mmio_sel), 32'h0);
        idle();

        // Reset while a tx byte is held.
        tx_ready = 1'b0;
        we = 1'b1; addr = A_TX; wdata = 32'h0000_00A5;
        tick();
        chk("tx_pre_rst", 32'(tx_valid), 32'h1);
        idle();
        do_reset("rst_tx");

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            rnd = $urandom;
            if (rnd[3:0] == 4'd0) begin
                rnd = $urandom;
                addr = {1'b0, rnd[30:0]};
            end else begin
                addr = addr_pool[$urandom_range(0, 7)];
                if (addr == A_CLR && $urandom_range(0, 3) != 0) addr = A_STATUS;
            end
            wdata      = $urandom;
            st_size    = 2'($urandom_range(0, 2));
            we         = ($urandom_range(0, 3) == 0);
            re         = ($urandom_range(0, 2) == 0);
            inst_valid = ($urandom_range(0, 1) == 1);
            tx_ready   = ($urandom_range(0, 2) == 0);
            rx_valid   = ($urandom_range(0, 2) == 0);
            rx_data    = 8'($urandom);
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
